// File: rtl/accum_drain.sv
// Snapshot a bank of LANES accumulators in one cycle and stream them out one lane per beat.
// Latency: first word valid 1 cycle after drain_start; LANES beats, then a 1-cycle done pulse.
// Backpressure: out_ready low stalls the current beat with data/lane/valid held stable.
// Optional macro ACCUM_DRAIN_RELU_EN: clamp negative (two's-complement) lane values to zero on out_data.
module accum_drain #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] acc_in,
    input  logic                   drain_start,
    output logic                   acc_clear,
    output logic                   busy,
    output logic [WIDTH-1:0]       out_data,
    output logic [LW-1:0]          out_lane,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [LW-1:0] LAST_IDX = LW'(LANES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q [LANES];
    logic [WIDTH-1:0]   shadow_d [LANES];
    logic [LW-1:0]      idx_q, idx_d;
    logic               acc_clear_q, acc_clear_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               done_q, done_d;

    // Output transform applied to a shadow value before it is registered onto out_data.
    function automatic logic [WIDTH-1:0] out_fn(input logic [WIDTH-1:0] v);
`ifdef ACCUM_DRAIN_RELU_EN
        return v[WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Next-state logic: capture in IDLE (or on the FIN exit edge so a start in the done cycle is not lost), step lanes in SEND.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        acc_clear_d = 1'b0;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if (state_q == FIN) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                end
                if (drain_start) begin
                    for (int i = 0; i < LANES; i++) begin
                        shadow_d[i] = acc_in[i*WIDTH +: WIDTH];
                    end
                    idx_d       = '0;
                    state_d     = SEND;
                    acc_clear_d = 1'b1;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = out_fn(acc_in[WIDTH-1:0]);
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = FIN;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = out_fn(shadow_q[idx_d]);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, shadow bank and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < LANES; i++) begin
                shadow_q[i] <= '0;
            end
            idx_q       <= '0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < LANES; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            idx_q       <= idx_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign acc_clear = acc_clear_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_accum_drain.sv
module tb_accum_drain;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int LW    = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [LANES*WIDTH-1:0] acc_in = '0;
    logic                   drain_start = 1'b0;
    logic                   acc_clear;
    logic                   busy;
    logic [WIDTH-1:0]       out_data;
    logic [LW-1:0]          out_lane;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   done;

    int checks = 0;
    int errors = 0;

    // expected stream for the pass in flight, one entry per lane
    logic [WIDTH-1:0] exp_v [LANES];

    accum_drain #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .acc_in(acc_in), .drain_start(drain_start),
        .acc_clear(acc_clear), .busy(busy), .out_data(out_data), .out_lane(out_lane),
        .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model_out(input logic [WIDTH-1:0] v);
`ifdef ACCUM_DRAIN_RELU_EN
        if ($signed(v) < 0) return '0;
        return v;
`else
        return v;
`endif
    endfunction

    function automatic logic [LANES*WIDTH-1:0] rand_acc();
        logic [LANES*WIDTH-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_model(input logic [LANES*WIDTH-1:0] a);
        for (int i = 0; i < LANES; i++) exp_v[i] = model_out(a[i*WIDTH +: WIDTH]);
    endtask

    // Pulse drain_start from IDLE; afterwards the bank is "restarted" with new contents.
    task automatic start_pass(input logic [LANES*WIDTH-1:0] a, input bit clobber);
        acc_in = a;
        capture_model(a);
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("acc_clear_after_start", acc_clear, 1);
        chk("busy_after_start", busy, 1);
        if (clobber) acc_in = '1;
        else         acc_in = rand_acc();
    endtask

    // mode 0: always ready, 1: 3-cycle stall on lane 1, 2: random ready
    task automatic stream(input int mode, input bit poke_start, input bit chain,
                          input logic [LANES*WIDTH-1:0] next_a);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        logic rdy;
        while (k < LANES && cyc < 200) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_lane", out_lane, k);
            chk("beat_data", out_data, exp_v[k]);
            chk("no_done_mid", done, 0);
            if (cyc > 0) chk("no_extra_clear", acc_clear, 0);
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = !(k == 1 && stall < 3);
                    if (!rdy) stall++;
                end
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            drain_start = poke_start && (cyc == 1);
            tick();
            drain_start = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        chk("beats_accepted", k, LANES);
        if (mode == 0) chk("back_to_back_cycles", cyc, LANES);
        chk("done_pulse", done, 1);
        chk("fin_valid_low", out_valid, 0);
        chk("fin_busy", busy, 1);
        out_ready = $urandom_range(0, 1);
        if (chain) begin
            acc_in = next_a;
            capture_model(next_a);
            drain_start = 1'b1;
            tick();
            drain_start = 1'b0;
            acc_in = rand_acc();
            chk("chain_clear", acc_clear, 1);
            chk("chain_valid", out_valid, 1);
            chk("chain_done_low", done, 0);
        end else begin
            tick();
            chk("done_single", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
            tick();
            chk("idle_stays", busy, 0);
        end
    endtask

    initial begin
        logic [LANES*WIDTH-1:0] base;
        logic [LANES*WIDTH-1:0] relu_vec;
        base     = {32'd40, 32'd30, 32'd20, 32'd10};
        relu_vec = {32'h0000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFFB};

        // reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lane", out_lane, 0);
        chk("rst_done", done, 0);
        chk("rst_clear", acc_clear, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // basic drain
        start_pass(base, 1'b0);
        stream(0, 1'b0, 1'b0, '0);

        // backpressure on lane 1
        start_pass(base, 1'b0);
        stream(1, 1'b0, 1'b0, '0);

        // snapshot isolation
        start_pass(base, 1'b1);
        stream(0, 1'b0, 1'b0, '0);

        // start ignored during SEND, then back-to-back start in the done cycle
        start_pass(base, 1'b0);
        stream(0, 1'b1, 1'b1, rand_acc());
        stream(2, 1'b0, 1'b0, '0);

        // sign handling
        start_pass(relu_vec, 1'b0);
        chk("relu_lane0", out_data, model_out(32'hFFFF_FFFB));
        stream(0, 1'b0, 1'b0, '0);

        // randomized passes with random backpressure
        for (int p = 0; p < 6; p++) begin
            start_pass(rand_acc(), 1'b0);
            stream(2, p[0], 1'b0, '0);
        end

        // reset mid-drain
        start_pass(base, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("pre_reset_lane", out_lane, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_lane", out_lane, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_clear", acc_clear, 0);
        tick();
        chk("rst_hold_done", done, 0);
        tick();
        chk("rst_hold_busy", busy, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_done", done, 0);
        start_pass(base, 1'b0);
        stream(0, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
